// File: rtl/v2i_seq_pkg.sv
// v2i_seq_pkg: shared types, constants and helpers for the V2I channel sequencer.
//
// Edge latencies of the sequencer, counted from the clock edge S that first
// samples a pending channel while the FSM is in IDLE:
//   - v2i_en[i] rises on edge S and the timer is loaded with SETTLE_CYC.
//   - CHECK is entered on edge S+SETTLE_CYC.
//   - ch_ok[i] rises on edge S+SETTLE_CYC+1 when ok_q[i] is already qualified.
//   - The next pending channel is enabled on the edge after that.
//   - A timeout fault is raised TIMEOUT_CYC edges after CHECK entry.
// ok_q needs SYNC_STAGES+DEB_CYC edges to follow ok_ana, in both directions.
// With SETTLE_CYC >= SYNC_STAGES+DEB_CYC, a brick whose ok is stable is
// already qualified by the time its channel reaches CHECK.
package v2i_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } seq_state_t;

  localparam int DEB_CYC     = 4;
  localparam int SYNC_STAGES = 2;

  // Width needed to hold the larger of the two timer reload values
  function automatic int timer_width(input int settle_cyc, input int timeout_cyc);
    int max_cyc;
    max_cyc = (settle_cyc > timeout_cyc) ? settle_cyc : timeout_cyc;
    return $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/v2i_ok_qual.sv
// v2i_ok_qual: synchroniser and debouncer for one brick's asynchronous ok flag.
// ok_s is the synchronised flag, ok_q the debounced flag, and ok_fall marks
// the cycle whose closing edge drops ok_q, so the loss of a running channel
// can be flagged on the same edge.
module v2i_ok_qual
  import v2i_seq_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic ok_ana,
  output logic ok_s,
  output logic ok_q,
  output logic ok_fall
);

  localparam int CW = $clog2(DEB_CYC);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   deb_last;

  assign ok_s     = sync[SYNC_STAGES-1];
  assign deb_last = (cnt == CW'(DEB_CYC - 1));
  assign ok_fall  = ok_q & ~ok_s & deb_last;

  // Shift the raw ok flag through the synchroniser chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ok_ana};
    end
  end

  // Flip ok_q only after DEB_CYC consecutive samples that disagree with it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      ok_q <= 1'b0;
    end else if (ok_s == ok_q) begin
      cnt <= '0;
    end else if (deb_last) begin
      cnt  <= '0;
      ok_q <= ok_s;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/v2i_channel_sequencer.sv
// v2i_channel_sequencer: stages V2I brick turn-on one channel at a time,
// qualifies each brick's ok flag and keeps a sticky per-channel fault.
// Optional feature: define V2I_SEQ_TEST_EN to add the ten bypass port.
module v2i_channel_sequencer
  import v2i_seq_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SETTLE_CYC  = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] en_req,
  input  logic [NCH-1:0] ok_ana,
  input  logic           fault_clr,
`ifdef V2I_SEQ_TEST_EN
  input  logic           ten,
`endif
  output logic [NCH-1:0] v2i_en,
  output logic [NCH-1:0] ch_ok,
  output logic [NCH-1:0] ch_fault,
  output logic           busy
);

  localparam int TW = timer_width(SETTLE_CYC, TIMEOUT_CYC);
  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;

  seq_state_t     state;
  logic [TW-1:0]  timer;
  logic [AW-1:0]  act;
  logic [NCH-1:0] ok_s;
  logic [NCH-1:0] ok_q;
  logic [NCH-1:0] ok_fall;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] act_vec;
  logic [NCH-1:0] start_vec;
  logic [NCH-1:0] ok_vec;
  logic [NCH-1:0] tmo_vec;
  logic [NCH-1:0] loss_vec;
  logic           pend_any;
  logic [AW-1:0]  pend_idx;
  logic           timer_last;
  logic           act_drop;
  logic           ok_hit;
  logic           tmo_hit;

  for (genvar g = 0; g < NCH; g++) begin : g_qual
    v2i_ok_qual u_qual (
      .clk     (clk),
      .rstn    (rstn),
      .ok_ana  (ok_ana[g]),
      .ok_s    (ok_s[g]),
      .ok_q    (ok_q[g]),
      .ok_fall (ok_fall[g])
    );
  end

  assign pending = en_req & ~v2i_en & ~ch_fault;

  // Pick the lowest-numbered pending channel
  always_comb begin
    pend_any = 1'b0;
    pend_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pend_any = 1'b1;
        pend_idx = AW'(i);
      end
    end
  end

  // Decode this cycle's events for the active channel and the whole bank
  always_comb begin
    act_vec       = '0;
    act_vec[act]  = 1'b1;
    timer_last    = (timer <= TW'(1));
    act_drop      = !en_req[act];
    ok_hit        = (state == CHECK) && !act_drop && ok_q[act] && ok_s[act];
    tmo_hit       = (state == CHECK) && !act_drop && !ok_hit && timer_last;
    start_vec     = '0;
    if ((state == IDLE) && pend_any) begin
      start_vec[pend_idx] = 1'b1;
    end
    ok_vec   = ok_hit ? act_vec : '0;
    tmo_vec  = tmo_hit ? act_vec : '0;
    loss_vec = ch_ok & ok_fall;
  end

`ifdef V2I_SEQ_TEST_EN
  logic ten_d;

  // Remember the previous test-enable level to spot its falling edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ten_d <= 1'b0;
    end else begin
      ten_d <= ten;
    end
  end
`endif

  // Sequencing FSM with registered enables, ok flags, faults and busy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      timer    <= '0;
      act      <= '0;
      v2i_en   <= '0;
      ch_ok    <= '0;
      ch_fault <= '0;
      busy     <= 1'b0;
    end else
`ifdef V2I_SEQ_TEST_EN
    if (ten) begin
      v2i_en <= en_req;
      ch_ok  <= ok_s;
      state  <= IDLE;
      timer  <= '0;
      busy   <= 1'b0;
    end else if (ten_d) begin
      v2i_en <= '0;
      ch_ok  <= '0;
      state  <= IDLE;
      timer  <= '0;
      busy   <= 1'b0;
    end else
`endif
    begin
      ch_fault <= (ch_fault & ~{NCH{fault_clr}}) | loss_vec | tmo_vec;
      v2i_en   <= (v2i_en & en_req & ~loss_vec & ~tmo_vec) | start_vec;
      ch_ok    <= (ch_ok & en_req & ~loss_vec) | ok_vec;
      case (state)
        IDLE: begin
          if (pend_any) begin
            act   <= pend_idx;
            timer <= TW'(SETTLE_CYC);
            state <= SETTLE;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (act_drop) begin
            timer <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timer_last) begin
            timer <= TW'(TIMEOUT_CYC);
            state <= CHECK;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        CHECK: begin
          if (act_drop || ok_hit || tmo_hit) begin
            timer <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          timer <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v2i_channel_sequencer.sv
// tb_v2i_channel_sequencer: directed table-driven bench for v2i_channel_sequencer
// (NCH=4, SETTLE_CYC=64, TIMEOUT_CYC=1024), plus hand-written multi-cycle sequences.
module tb_v2i_channel_sequencer;

  localparam int NCH     = 4;
  localparam int SETTLE  = 64;
  localparam int TIMEOUT = 1024;

  typedef struct {
    string          name;
    logic [NCH-1:0] en_req;
    logic [NCH-1:0] ok_ana;
    logic           fault_clr;
    int             edges;
    logic [NCH-1:0] exp_en;
    logic [NCH-1:0] exp_ok;
    logic [NCH-1:0] exp_fault;
    logic           exp_busy;
  } vec_t;

  logic           clk;
  logic           rstn;
  logic [NCH-1:0] en_req;
  logic [NCH-1:0] ok_ana;
  logic           fault_clr;
  logic           ten;
  logic [NCH-1:0] v2i_en;
  logic [NCH-1:0] ch_ok;
  logic [NCH-1:0] ch_fault;
  logic           busy;

  int   vec_count;
  int   miscompares;
  vec_t vecs[$];

  v2i_channel_sequencer #(
    .NCH         (NCH),
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en_req    (en_req),
    .ok_ana    (ok_ana),
    .fault_clr (fault_clr),
`ifdef V2I_SEQ_TEST_EN
    .ten       (ten),
`endif
    .v2i_en    (v2i_en),
    .ch_ok     (ch_ok),
    .ch_fault  (ch_fault),
    .busy      (busy)
  );

  // Free-running block clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t make_vec(input string name, input logic [NCH-1:0] en,
                                    input logic [NCH-1:0] ok, input logic clr, input int edges,
                                    input logic [NCH-1:0] e_en, input logic [NCH-1:0] e_ok,
                                    input logic [NCH-1:0] e_flt, input logic e_busy);
    vec_t v;
    v.name      = name;
    v.en_req    = en;
    v.ok_ana    = ok;
    v.fault_clr = clr;
    v.edges     = edges;
    v.exp_en    = e_en;
    v.exp_ok    = e_ok;
    v.exp_fault = e_flt;
    v.exp_busy  = e_busy;
    return v;
  endfunction

  task automatic apply_stimulus(input logic [NCH-1:0] en, input logic [NCH-1:0] ok, input logic clr);
    en_req    = en;
    ok_ana    = ok;
    fault_clr = clr;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [NCH-1:0] e_en, input logic [NCH-1:0] e_ok,
                              input logic [NCH-1:0] e_flt, input logic e_busy);
    vec_count++;
    if (v2i_en !== e_en || ch_ok !== e_ok || ch_fault !== e_flt || busy !== e_busy) begin
      miscompares++;
      $display("[TB] FAIL %s: got v2i_en=%b ch_ok=%b ch_fault=%b busy=%b, want v2i_en=%b ch_ok=%b ch_fault=%b busy=%b",
               name, v2i_en, ch_ok, ch_fault, busy, e_en, e_ok, e_flt, e_busy);
    end
  endtask

  // Directed test sequence
  initial begin
    vec_count   = 0;
    miscompares = 0;
    ten         = 1'b0;
    rstn        = 1'b0;
    apply_stimulus(4'b0000, 4'hF, 1'b0);

    // Staged turn-on of channels 0,1,3: each takes SETTLE+2 edges
    vecs.push_back(make_vec("seq_ch0_en",     4'b1011, 4'hF, 1'b0, 1,          4'b0001, 4'b0000, 4'b0000, 1'b1));
    vecs.push_back(make_vec("seq_ch0_check",  4'b1011, 4'hF, 1'b0, SETTLE,     4'b0001, 4'b0000, 4'b0000, 1'b1));
    vecs.push_back(make_vec("seq_ch0_ok",     4'b1011, 4'hF, 1'b0, 1,          4'b0001, 4'b0001, 4'b0000, 1'b0));
    vecs.push_back(make_vec("seq_ch1_en",     4'b1011, 4'hF, 1'b0, 1,          4'b0011, 4'b0001, 4'b0000, 1'b1));
    vecs.push_back(make_vec("seq_ch1_ok",     4'b1011, 4'hF, 1'b0, SETTLE + 1, 4'b0011, 4'b0011, 4'b0000, 1'b0));
    vecs.push_back(make_vec("seq_ch3_en",     4'b1011, 4'hF, 1'b0, 1,          4'b1011, 4'b0011, 4'b0000, 1'b1));
    vecs.push_back(make_vec("seq_ch3_ok",     4'b1011, 4'hF, 1'b0, SETTLE + 1, 4'b1011, 4'b1011, 4'b0000, 1'b0));
    vecs.push_back(make_vec("seq_all_stable", 4'b1011, 4'hF, 1'b0, 5,          4'b1011, 4'b1011, 4'b0000, 1'b0));

    repeat (2) @(negedge clk);
    check_output("reset_state", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rstn = 1'b1;
    run_edges(10);
    check_output("idle_no_request", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].en_req, vecs[i].ok_ana, vecs[i].fault_clr);
      run_edges(vecs[i].edges);
      check_output(vecs[i].name, vecs[i].exp_en, vecs[i].exp_ok, vecs[i].exp_fault, vecs[i].exp_busy);
    end

    // Run-time loss: a 3-cycle glitch is filtered, a sustained drop faults on edge 6
    apply_stimulus(4'b1011, 4'b1110, 1'b0);
    run_edges(3);
    apply_stimulus(4'b1011, 4'b1111, 1'b0);
    run_edges(10);
    check_output("glitch_filtered", 4'b1011, 4'b1011, 4'b0000, 1'b0);
    apply_stimulus(4'b1011, 4'b1110, 1'b0);
    run_edges(5);
    check_output("loss_edge5", 4'b1011, 4'b1011, 4'b0000, 1'b0);
    run_edges(1);
    check_output("loss_edge6", 4'b1010, 4'b1010, 4'b0001, 1'b0);

    // Timeout on channel 2 with a coincident fault_clr, then re-sequencing
    apply_stimulus(4'b1011, 4'b1011, 1'b0);
    run_edges(10);
    check_output("fault_sticky", 4'b1010, 4'b1010, 4'b0001, 1'b0);
    apply_stimulus(4'b1111, 4'b1011, 1'b0);
    run_edges(1);
    check_output("ch2_en", 4'b1110, 4'b1010, 4'b0001, 1'b1);
    run_edges(SETTLE);
    check_output("ch2_check_entry", 4'b1110, 4'b1010, 4'b0001, 1'b1);
    run_edges(TIMEOUT - 1);
    check_output("ch2_before_timeout", 4'b1110, 4'b1010, 4'b0001, 1'b1);
    apply_stimulus(4'b1111, 4'b1011, 1'b1);
    run_edges(1);
    check_output("ch2_timeout_beats_clr", 4'b1010, 4'b1010, 4'b0100, 1'b0);
    apply_stimulus(4'b1111, 4'b1011, 1'b0);
    run_edges(1);
    check_output("ch0_resequence", 4'b1011, 4'b1010, 4'b0100, 1'b1);
    run_edges(SETTLE + 1);
    check_output("ch0_ok_again", 4'b1011, 4'b1011, 4'b0100, 1'b0);
    apply_stimulus(4'b1111, 4'b1011, 1'b1);
    run_edges(1);
    check_output("second_clr", 4'b1011, 4'b1011, 4'b0000, 1'b0);
    apply_stimulus(4'b1111, 4'b1011, 1'b0);
    run_edges(1);
    check_output("ch2_resequence", 4'b1111, 4'b1011, 4'b0000, 1'b1);
    run_edges(5);
    apply_stimulus(4'b1011, 4'b1011, 1'b0);
    run_edges(1);
    check_output("ch2_drop", 4'b1011, 4'b1011, 4'b0000, 1'b0);

    // Asynchronous reset with channels running, then restart from channel 1
    rstn = 1'b0;
    #1;
    check_output("reset_async", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    apply_stimulus(4'b1010, 4'hF, 1'b0);
    rstn = 1'b1;
    run_edges(1);
    check_output("restart_ch1", 4'b0010, 4'b0000, 4'b0000, 1'b1);
    run_edges(10);
    apply_stimulus(4'b1000, 4'hF, 1'b0);
    run_edges(1);
    check_output("ch1_drop_settle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run_edges(1);
    check_output("ch3_next_edge", 4'b1000, 4'b0000, 4'b0000, 1'b1);
    run_edges(SETTLE);
    check_output("ch3_check_entry", 4'b1000, 4'b0000, 4'b0000, 1'b1);

    // Reset while channel 3 sits in CHECK, then restart from the lowest pending channel
    rstn = 1'b0;
    #1;
    check_output("reset_mid_check", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    apply_stimulus(4'b1010, 4'hF, 1'b0);
    rstn = 1'b1;
    run_edges(1);
    check_output("after_reset_ch1", 4'b0010, 4'b0000, 4'b0000, 1'b1);
    run_edges(SETTLE + 1);
    check_output("after_reset_ch1_ok", 4'b0010, 4'b0010, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
